pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It replaces the separate hazard unit and forwarding unit with one block. It keeps a scoreboard of in-flight destination registers from EX through writeback, and from it produces:
- load-use stalls and ID-stage branch-operand stalls;
- branch/jump flushes;
- multi-cycle (long-op) freezes;
- EX operand forwarding selects over a configurable number of forwarding stages.

---
 rtl/pipe_hazard_ctrl_if.sv | 70 +++++++
 rtl/pipe_hazard_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the 5-stage MIPS datapath and the combined hazard/forwarding
// controller.
//
// Pipeline side drives (modport master -> outputs):
//   id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en, id_wr_reg,
//   id_is_load, id_is_long, id_is_branch, id_branch_taken, id_is_jump
// Controller side drives (modport slave -> outputs):
//   pc_ld, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
//   fwd_a_sel, fwd_b_sel
//   br_fwd_a_sel, br_fwd_b_sel  (only when ID_BRANCH_FWD_EN is defined)
//
// Optional feature macro: ID_BRANCH_FWD_EN
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2
);
  localparam int SW = $clog2(FWD_DEPTH + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_wr_reg;
  logic              id_is_load;
  logic              id_is_long;
  logic              id_is_branch;
  logic              id_branch_taken;
  logic              id_is_jump;

  logic              pc_ld;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              ex_hold;
  logic [SW-1:0]     fwd_a_sel;
  logic [SW-1:0]     fwd_b_sel;
`ifdef ID_BRANCH_FWD_EN
  logic [SW-1:0]     br_fwd_a_sel;
  logic [SW-1:0]     br_fwd_b_sel;
`endif

  // Datapath / pipeline side
  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en,
           id_wr_reg, id_is_load, id_is_long, id_is_branch,
           id_branch_taken, id_is_jump,
`ifdef ID_BRANCH_FWD_EN
    input  br_fwd_a_sel, br_fwd_b_sel,
`endif
    input  pc_ld, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
           fwd_a_sel, fwd_b_sel
  );

  // Controller side
  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en,
           id_wr_reg, id_is_load, id_is_long, id_is_branch,
           id_branch_taken, id_is_jump,
`ifdef ID_BRANCH_FWD_EN
    output br_fwd_a_sel, br_fwd_b_sel,
`endif
    output pc_ld, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
           fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Combined hazard and forwarding controller for the 5-stage MIPS pipeline.
// A scoreboard of in-flight destinations (EX .. writeback) drives load-use
// and ID-branch stalls, branch/jump flushes, long-op freezes and the EX
// operand forwarding selects.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - pipe_hazard_ctrl_if.slave: ID-stage decode info in, pipeline
//          control (pc_ld, if_id_write, if_id_flush, id_ex_bubble, ex_hold)
//          and forwarding selects out
//
// Parameters: REG_AW (register address width), FWD_DEPTH (forwarding stages
// after EX, E[FWD_DEPTH] is writeback), LONG_LAT (EX occupancy of a long op).
//
// Optional feature macro: ID_BRANCH_FWD_EN -- adds forwarding into the ID
// branch comparator (br_fwd_a_sel / br_fwd_b_sel) and narrows the branch
// stall accordingly.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int LONG_LAT  = 4
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int SW = $clog2(FWD_DEPTH + 1);
  localparam int CW = $clog2(LONG_LAT);

  // Scoreboard: index 0 is EX, index FWD_DEPTH is writeback
  logic              entValid  [0:FWD_DEPTH];
  logic              entWrEn   [0:FWD_DEPTH];
  logic [REG_AW-1:0] entWrReg  [0:FWD_DEPTH];
  logic              entIsLoad [0:FWD_DEPTH];
  logic [REG_AW-1:0] exRs;
  logic [REG_AW-1:0] exRt;
  logic [CW-1:0]     longCnt;

  logic              isProd [0:FWD_DEPTH];
  logic              idHit  [0:FWD_DEPTH];
  logic [REG_AW-1:0] idRsEff;
  logic [REG_AW-1:0] idRtEff;
  logic              held;
  logic              loadStall;
  logic              brHazard;
  logic              brStall;
  logic              stall;
  logic              redirect;
  logic              issue;
  logic [SW-1:0]     exFwdA;
  logic [SW-1:0]     exFwdB;

  // An unused source is treated as r0, which can never match a producer,
  // so the comparisons below need no separate "uses" qualifier.
  assign idRsEff = bus.id_uses_rs ? bus.id_rs : '0;
  assign idRtEff = bus.id_uses_rt ? bus.id_rt : '0;
  assign held    = (longCnt != '0);

  // Classify each scoreboard slot as a real producer and flag whether the
  // instruction sitting in ID reads its destination.
  always_comb begin
    for (int k = 0; k <= FWD_DEPTH; k++) begin
      isProd[k] = entValid[k] && entWrEn[k] && (entWrReg[k] != '0);
      idHit[k]  = isProd[k] && ((idRsEff == entWrReg[k]) || (idRtEff == entWrReg[k]));
    end
  end

  // Branch operand hazard. Without ID forwarding the branch must wait until
  // every producer reaches writeback (register file writes before it reads).
  // With ID forwarding only EX results and loads one stage later are unready.
  always_comb begin
    brHazard = 1'b0;
`ifdef ID_BRANCH_FWD_EN
    brHazard = idHit[0] || (idHit[1] && entIsLoad[1]);
`else
    for (int k = 0; k < FWD_DEPTH; k++) begin
      brHazard = brHazard || idHit[k];
    end
`endif
  end

  // Stall/redirect decisions; a long-op hold overrides both, and a stall
  // suppresses redirect so the branch re-evaluates with fresh operands.
  assign loadStall = bus.id_valid && idHit[0] && entIsLoad[0];
  assign brStall   = bus.id_valid && bus.id_is_branch && brHazard;
  assign stall     = !held && (loadStall || brStall);
  assign redirect  = !held && !stall && bus.id_valid &&
                     (bus.id_is_jump || (bus.id_is_branch && bus.id_branch_taken));
  assign issue     = bus.id_valid && !stall;

  // EX operand forwarding: walk from the oldest stage toward EX so the
  // nearest matching producer is the one left in the select.
  always_comb begin
    exFwdA = '0;
    exFwdB = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (isProd[k] && (entWrReg[k] == exRs)) exFwdA = SW'(k);
      if (isProd[k] && (entWrReg[k] == exRt)) exFwdB = SW'(k);
    end
  end

`ifdef ID_BRANCH_FWD_EN
  logic [SW-1:0] brFwdA;
  logic [SW-1:0] brFwdB;

  // ID comparator forwarding from the post-EX stages short of writeback;
  // load results are excluded because brHazard already stalls on them.
  always_comb begin
    brFwdA = '0;
    brFwdB = '0;
    for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
      if (isProd[k] && !entIsLoad[k] && (entWrReg[k] == idRsEff)) brFwdA = SW'(k);
      if (isProd[k] && !entIsLoad[k] && (entWrReg[k] == idRtEff)) brFwdB = SW'(k);
    end
  end

  assign bus.br_fwd_a_sel = rst ? '0 : brFwdA;
  assign bus.br_fwd_b_sel = rst ? '0 : brFwdB;
`endif

  // Pipeline control outputs, in priority order: reset, long-op hold,
  // stall, redirect, normal advance.
  always_comb begin
    bus.pc_ld        = 1'b1;
    bus.if_id_write  = 1'b1;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    bus.ex_hold      = 1'b0;
    bus.fwd_a_sel    = '0;
    bus.fwd_b_sel    = '0;
    if (!rst) begin
      bus.fwd_a_sel = exFwdA;
      bus.fwd_b_sel = exFwdB;
      if (held) begin
        bus.ex_hold     = 1'b1;
        bus.pc_ld       = 1'b0;
        bus.if_id_write = 1'b0;
      end else if (stall) begin
        bus.pc_ld        = 1'b0;
        bus.if_id_write  = 1'b0;
        bus.id_ex_bubble = 1'b1;
      end else if (redirect) begin
        bus.if_id_flush = 1'b1;
      end
    end
  end

  // Scoreboard shift and long-op counter. During a hold everything is
  // frozen except the countdown; the EX instruction leaves on the cycle the
  // counter is back at zero. A bubble enters EX with its sources cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= FWD_DEPTH; k++) begin
        entValid[k]  <= 1'b0;
        entWrEn[k]   <= 1'b0;
        entWrReg[k]  <= '0;
        entIsLoad[k] <= 1'b0;
      end
      exRs    <= '0;
      exRt    <= '0;
      longCnt <= '0;
    end else if (held) begin
      longCnt <= longCnt - CW'(1);
    end else begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        entValid[k]  <= entValid[k-1];
        entWrEn[k]   <= entWrEn[k-1];
        entWrReg[k]  <= entWrReg[k-1];
        entIsLoad[k] <= entIsLoad[k-1];
      end
      entValid[0]  <= issue;
      entWrEn[0]   <= issue && bus.id_wr_en;
      entWrReg[0]  <= issue ? bus.id_wr_reg : '0;
      entIsLoad[0] <= issue && bus.id_is_load;
      exRs         <= issue ? idRsEff : '0;
      exRt         <= issue ? idRtEff : '0;
      longCnt      <= (issue && bus.id_is_long) ? CW'(LONG_LAT - 1) : '0;
    end
  end

  // A load one stage past EX must never feed the instruction in EX;
  // loadStall exists precisely to keep that from happening.
  noLoadUseInEx: assert property (@(posedge clk) disable iff (rst)
    !(isProd[1] && entIsLoad[1] && ((entWrReg[1] == exRs) || (entWrReg[1] == exRt))));
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed scenarios followed by random instruction streams, each cycle
// compared against an instruction-level model of the pipeline.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  localparam int REG_AW    = 5;
  localparam int FWD_DEPTH = 2;
  localparam int LONG_LAT  = 4;
  localparam int SW        = $clog2(FWD_DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic              usesRs;
    logic              usesRt;
    logic              wrEn;
    logic              isLoad;
    logic              isLong;
    logic              isBranch;
    logic              taken;
    logic              isJump;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] wrReg;
  } instr_t;

  typedef struct packed {
    logic          pcLd;
    logic          ifIdWrite;
    logic          ifIdFlush;
    logic          idExBubble;
    logic          exHold;
    logic [SW-1:0] fwdA;
    logic [SW-1:0] fwdB;
    logic [SW-1:0] brA;
    logic [SW-1:0] brB;
  } expect_t;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  // Model: the instructions occupying EX .. writeback, plus long-op cycles left
  instr_t  pipe [0:FWD_DEPTH];
  int      holdLeft;
  instr_t  curIn;
  logic    curRst;
  expect_t exp;

  pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH)) bus ();

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH), .LONG_LAT(LONG_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction constructors
  function automatic instr_t mkNop();
    instr_t i = '0;
    i.valid = 1'b1;
    return i;
  endfunction

  function automatic instr_t mkAlu(input int rd, input int rs, input int rt);
    instr_t i = mkNop();
    i.usesRs = 1'b1; i.usesRt = 1'b1; i.wrEn = 1'b1;
    i.rs = REG_AW'(rs); i.rt = REG_AW'(rt); i.wrReg = REG_AW'(rd);
    return i;
  endfunction

  function automatic instr_t mkLoad(input int rd, input int base);
    instr_t i = mkNop();
    i.usesRs = 1'b1; i.wrEn = 1'b1; i.isLoad = 1'b1;
    i.rs = REG_AW'(base); i.wrReg = REG_AW'(rd);
    return i;
  endfunction

  function automatic instr_t mkLong(input int rd, input int rs, input int rt);
    instr_t i = mkAlu(rd, rs, rt);
    i.isLong = 1'b1;
    return i;
  endfunction

  function automatic instr_t mkBranch(input int rs, input int rt, input bit tk);
    instr_t i = mkNop();
    i.usesRs = 1'b1; i.usesRt = 1'b1; i.isBranch = 1'b1; i.taken = tk;
    i.rs = REG_AW'(rs); i.rt = REG_AW'(rt);
    return i;
  endfunction

  function automatic instr_t mkJump(input bit readsRs, input int rs);
    instr_t i = mkNop();
    i.isJump = 1'b1; i.usesRs = readsRs; i.rs = REG_AW'(rs);
    return i;
  endfunction

  function automatic instr_t randInstr();
    instr_t i;
    int kind;
    kind = int'($urandom_range(0, 9));
    case (kind)
      0, 1, 2, 3: i = mkAlu(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      4, 5:       i = mkLoad(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      6:          i = mkLong(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      7:          i = mkBranch(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      8:          i = mkJump(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      default: begin
        i = mkAlu(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        i.wrEn = 1'b0;
      end
    endcase
    i.valid = ($urandom_range(0, 7) != 0);
    return i;
  endfunction

  // Model rules
  function automatic bit isProducer(input instr_t e);
    return e.valid && e.wrEn && (e.wrReg != 0);
  endfunction

  function automatic bit idReads(input instr_t in, input logic [REG_AW-1:0] r);
    return (in.usesRs && in.rs == r) || (in.usesRt && in.rt == r);
  endfunction

  function automatic bit modelStall(input instr_t in);
    bit loadStall, brHaz;
    if (holdLeft != 0) return 1'b0;
    loadStall = in.valid && isProducer(pipe[0]) && pipe[0].isLoad && idReads(in, pipe[0].wrReg);
    brHaz = 1'b0;
`ifdef ID_BRANCH_FWD_EN
    brHaz = (isProducer(pipe[0]) && idReads(in, pipe[0].wrReg)) ||
            (isProducer(pipe[1]) && pipe[1].isLoad && idReads(in, pipe[1].wrReg));
`else
    for (int k = 0; k < FWD_DEPTH; k++)
      if (isProducer(pipe[k]) && idReads(in, pipe[k].wrReg)) brHaz = 1'b1;
`endif
    return loadStall || (in.valid && in.isBranch && brHaz);
  endfunction

  function automatic expect_t modelExpect(input instr_t in, input logic r);
    expect_t e = '0;
    e.pcLd = 1'b1;
    e.ifIdWrite = 1'b1;
    if (r) return e;
    // Nearest producer of each EX source, scanning outward from EX
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      if (e.fwdA == 0 && pipe[0].valid && pipe[0].usesRs && isProducer(pipe[k]) && pipe[k].wrReg == pipe[0].rs)
        e.fwdA = SW'(k);
      if (e.fwdB == 0 && pipe[0].valid && pipe[0].usesRt && isProducer(pipe[k]) && pipe[k].wrReg == pipe[0].rt)
        e.fwdB = SW'(k);
    end
`ifdef ID_BRANCH_FWD_EN
    for (int k = 1; k < FWD_DEPTH; k++) begin
      if (e.brA == 0 && in.usesRs && isProducer(pipe[k]) && !pipe[k].isLoad && pipe[k].wrReg == in.rs)
        e.brA = SW'(k);
      if (e.brB == 0 && in.usesRt && isProducer(pipe[k]) && !pipe[k].isLoad && pipe[k].wrReg == in.rt)
        e.brB = SW'(k);
    end
`endif
    if (holdLeft != 0) begin
      e.exHold = 1'b1; e.pcLd = 1'b0; e.ifIdWrite = 1'b0;
    end else if (modelStall(in)) begin
      e.pcLd = 1'b0; e.ifIdWrite = 1'b0; e.idExBubble = 1'b1;
    end else if (in.valid && (in.isJump || (in.isBranch && in.taken))) begin
      e.ifIdFlush = 1'b1;
    end
    return e;
  endfunction

  task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of ID inputs and move to the sampling edge
  task automatic applyStimulus(input instr_t in, input logic r);
    curIn  = in;
    curRst = r;
    rst                 = r;
    bus.id_valid        = in.valid;
    bus.id_rs           = in.rs;
    bus.id_rt           = in.rt;
    bus.id_uses_rs      = in.usesRs;
    bus.id_uses_rt      = in.usesRt;
    bus.id_wr_en        = in.wrEn;
    bus.id_wr_reg       = in.wrReg;
    bus.id_is_load      = in.isLoad;
    bus.id_is_long      = in.isLong;
    bus.id_is_branch    = in.isBranch;
    bus.id_branch_taken = in.taken;
    bus.id_is_jump      = in.isJump;
    @(negedge clk);
  endtask

  // Compare every output against the model for the current cycle
  task automatic checkOutput();
    exp = modelExpect(curIn, curRst);
    checkOne("pc_ld",        32'(bus.pc_ld),        32'(exp.pcLd));
    checkOne("if_id_write",  32'(bus.if_id_write),  32'(exp.ifIdWrite));
    checkOne("if_id_flush",  32'(bus.if_id_flush),  32'(exp.ifIdFlush));
    checkOne("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(exp.idExBubble));
    checkOne("ex_hold",      32'(bus.ex_hold),      32'(exp.exHold));
    checkOne("fwd_a_sel",    32'(bus.fwd_a_sel),    32'(exp.fwdA));
    checkOne("fwd_b_sel",    32'(bus.fwd_b_sel),    32'(exp.fwdB));
`ifdef ID_BRANCH_FWD_EN
    checkOne("br_fwd_a_sel", 32'(bus.br_fwd_a_sel), 32'(exp.brA));
    checkOne("br_fwd_b_sel", 32'(bus.br_fwd_b_sel), 32'(exp.brB));
`endif
  endtask

  // Advance the model across the clock edge
  task automatic tick();
    bit st;
    st = modelStall(curIn);
    @(posedge clk);
    if (curRst) begin
      for (int k = 0; k <= FWD_DEPTH; k++) pipe[k] = '0;
      holdLeft = 0;
    end else if (holdLeft != 0) begin
      holdLeft--;
    end else begin
      for (int k = FWD_DEPTH; k >= 1; k--) pipe[k] = pipe[k-1];
      pipe[0] = (curIn.valid && !st) ? curIn : '0;
      if (pipe[0].valid && pipe[0].isLong) holdLeft = LONG_LAT - 1;
    end
    #1;
  endtask

  task automatic cycle(input instr_t in);
    applyStimulus(in, 1'b0);
    checkOutput();
    tick();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(mkNop());
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    holdLeft    = 0;
    for (int k = 0; k <= FWD_DEPTH; k++) pipe[k] = '0;

    // Reset forces outputs regardless of a hazardous-looking ID instruction
    applyStimulus(mkLoad(6, 1), 1'b1); checkOutput();
    checkOne("rstPcLd", 32'(bus.pc_ld), 32'd1);
    checkOne("rstHold", 32'(bus.ex_hold), 32'd0);
    checkOne("rstBubble", 32'(bus.id_ex_bubble), 32'd0);
    tick();
    applyStimulus(mkBranch(6, 6, 1'b1), 1'b1); checkOutput();
    checkOne("rstFlush", 32'(bus.if_id_flush), 32'd0);
    checkOne("rstIfIdWrite", 32'(bus.if_id_write), 32'd1);
    tick();

    // add r3,r1,r2 ; sub r4,r3,r1
    cycle(mkAlu(3, 1, 2));
    applyStimulus(mkAlu(4, 3, 1), 1'b0); checkOutput();
    checkOne("subNoStall", 32'(bus.id_ex_bubble), 32'd0);
    tick();
    applyStimulus(mkNop(), 1'b0); checkOutput();
    checkOne("subFwdA", 32'(bus.fwd_a_sel), 32'd1);
    checkOne("subFwdB", 32'(bus.fwd_b_sel), 32'd0);
    tick();
    drain(3);

    // add r3 ; nop ; or r5,r0,r3  then  add r0 ; or r5,r0,r0
    cycle(mkAlu(3, 1, 2));
    cycle(mkNop());
    cycle(mkAlu(5, 0, 3));
    applyStimulus(mkAlu(0, 1, 2), 1'b0); checkOutput();
    checkOne("orFwdB", 32'(bus.fwd_b_sel), 32'd2);
    checkOne("orFwdA", 32'(bus.fwd_a_sel), 32'd0);
    tick();
    cycle(mkAlu(5, 0, 0));
    applyStimulus(mkNop(), 1'b0); checkOutput();
    checkOne("r0FwdA", 32'(bus.fwd_a_sel), 32'd0);
    checkOne("r0FwdB", 32'(bus.fwd_b_sel), 32'd0);
    tick();
    drain(3);

    // lw r6,0(r1) ; add r7,r6,r6
    cycle(mkLoad(6, 1));
    applyStimulus(mkAlu(7, 6, 6), 1'b0); checkOutput();
    checkOne("luBubble", 32'(bus.id_ex_bubble), 32'd1);
    checkOne("luPcLd", 32'(bus.pc_ld), 32'd0);
    checkOne("luIfIdWrite", 32'(bus.if_id_write), 32'd0);
    tick();
    applyStimulus(mkAlu(7, 6, 6), 1'b0); checkOutput();
    checkOne("luReleased", 32'(bus.id_ex_bubble), 32'd0);
    tick();
    applyStimulus(mkNop(), 1'b0); checkOutput();
    checkOne("luFwdA", 32'(bus.fwd_a_sel), 32'd2);
    checkOne("luFwdB", 32'(bus.fwd_b_sel), 32'd2);
    tick();
    drain(3);

    // add r8 ; beq r8,r8 taken
    cycle(mkAlu(8, 1, 2));
    applyStimulus(mkBranch(8, 8, 1'b1), 1'b0); checkOutput();
    checkOne("brStall1", 32'(bus.id_ex_bubble), 32'd1);
    checkOne("brNoFlush1", 32'(bus.if_id_flush), 32'd0);
    tick();
`ifdef ID_BRANCH_FWD_EN
    applyStimulus(mkBranch(8, 8, 1'b1), 1'b0); checkOutput();
    checkOne("brFlushFwd", 32'(bus.if_id_flush), 32'd1);
    checkOne("brFwdSelA", 32'(bus.br_fwd_a_sel), 32'd1);
    tick();
`else
    applyStimulus(mkBranch(8, 8, 1'b1), 1'b0); checkOutput();
    checkOne("brStall2", 32'(bus.id_ex_bubble), 32'd1);
    checkOne("brNoFlush2", 32'(bus.if_id_flush), 32'd0);
    tick();
    applyStimulus(mkBranch(8, 8, 1'b1), 1'b0); checkOutput();
    checkOne("brFlush", 32'(bus.if_id_flush), 32'd1);
    checkOne("brFlushPcLd", 32'(bus.pc_ld), 32'd1);
    tick();
`endif
    drain(3);

    // long op r9 ; add r10,r9,r1 : three hold cycles then forward
    cycle(mkLong(9, 1, 2));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mkAlu(10, 9, 1), 1'b0); checkOutput();
      checkOne("longHold", 32'(bus.ex_hold), 32'd1);
      tick();
    end
    applyStimulus(mkAlu(10, 9, 1), 1'b0); checkOutput();
    checkOne("longDone", 32'(bus.ex_hold), 32'd0);
    checkOne("longNoStall", 32'(bus.id_ex_bubble), 32'd0);
    tick();
    applyStimulus(mkNop(), 1'b0); checkOutput();
    checkOne("longFwdA", 32'(bus.fwd_a_sel), 32'd1);
    tick();
    drain(3);

    // long op abandoned by reset in its second hold cycle
    cycle(mkLong(9, 1, 2));
    cycle(mkNop());
    applyStimulus(mkNop(), 1'b1); checkOutput();
    checkOne("rstInHold", 32'(bus.ex_hold), 32'd0);
    tick();
    applyStimulus(mkBranch(9, 9, 1'b0), 1'b0); checkOutput();
    checkOne("postRstHold", 32'(bus.ex_hold), 32'd0);
    checkOne("postRstNoStall", 32'(bus.id_ex_bubble), 32'd0);
    tick();
    drain(3);

    // lw r11 ; j reading r11 : stall beats flush, flush follows
    cycle(mkLoad(11, 1));
    applyStimulus(mkJump(1'b1, 11), 1'b0); checkOutput();
    checkOne("jStall", 32'(bus.id_ex_bubble), 32'd1);
    checkOne("jNoFlush", 32'(bus.if_id_flush), 32'd0);
    tick();
    applyStimulus(mkJump(1'b1, 11), 1'b0); checkOutput();
    checkOne("jFlush", 32'(bus.if_id_flush), 32'd1);
    checkOne("jPcLd", 32'(bus.pc_ld), 32'd1);
    tick();

    // Random instruction streams with occasional reset
    for (int n = 0; n < 800; n++) begin
      applyStimulus(randInstr(), ($urandom_range(0, 59) == 0));
      checkOutput();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
